layers_frames_arbiter: RTL

Shares the single downstream frame stream among the per-layer SPI interfaces. Each layer interface delivers decoded frame bytes on its own AXI-Stream port in the clk_core domain. This block grants one layer at a time with round-robin fairness and holds the grant for a whole frame, until the beat carrying tlast. The output is one registered AXI-Stream port that feeds the readout buffer/host FIFO.

---
 rtl/layers_arb_pkg.sv | 29 ++
 rtl/layers_frames_arbiter_rr_priority_pick.sv | 30 +++
 rtl/layers_frames_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/layers_arb_pkg.sv
// Shared types and constants for the layer frame arbiter.
// LAYERS_ARB_TIMEOUT_EN enables the stall-timeout FLUSH path in the top.
package layers_arb_pkg;

    localparam int unsigned ARB_TIMEOUT_W   = 16;
    localparam logic [7:0]  ARB_FILLER_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        FLUSH  = 2'd2
    } arb_state_t;

    // One output beat as held in the output register
    typedef struct packed {
        logic       last;
        logic [7:0] dest;
        logic [7:0] data;
    } arb_beat_t;

    // (a + b) mod n for a, b < n
    function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/layers_frames_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping modulo N.
module rr_priority_pick
    import layers_arb_pkg::*;
#(
    parameter int unsigned N    = 3,
    parameter int unsigned ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [ID_W-1:0] winner_o,
    output logic            found_o
);

    logic [ID_W-1:0] cand;

    always_comb begin
        winner_o = '0;
        found_o  = 1'b0;
        cand     = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = ID_W'(wrap_add(32'(ptr_i), off, N));
            if (!found_o && req_i[cand]) begin
                found_o  = 1'b1;
                winner_o = cand;
            end
        end
    end

endmodule

// File: rtl/layers_frames_arbiter.sv
// Frame-granular round-robin merge of NLAYERS AXI-Stream byte lanes into one
// registered output. LAYERS_ARB_TIMEOUT_EN adds a stall timeout with FLUSH.
module layers_frames_arbiter
    import layers_arb_pkg::*;
#(
    parameter int unsigned NLAYERS  = 3,
    parameter int unsigned ARB_ID_W = $clog2(NLAYERS)
) (
    input  logic                     clk_core,
    input  logic                     clk_core_rst,
    input  logic [NLAYERS*8-1:0]     s_axis_tdata,
    input  logic [NLAYERS*8-1:0]     s_axis_tdest,
    input  logic [NLAYERS-1:0]       s_axis_tlast,
    input  logic [NLAYERS-1:0]       s_axis_tvalid,
    output logic [NLAYERS-1:0]       s_axis_tready,
    output logic [7:0]               m_axis_tdata,
    output logic [7:0]               m_axis_tdest,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    input  logic [NLAYERS-1:0]       cfg_layer_enable,
    input  logic [ARB_TIMEOUT_W-1:0] cfg_timeout,
    output logic [NLAYERS-1:0]       stat_grant,
    output logic [ARB_TIMEOUT_W-1:0] stat_timeout_count
);

    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_LOCKED = 2'(LOCKED);
    localparam logic [1:0] ST_FLUSH  = 2'(FLUSH);

    logic [1:0]          state_q, state_d;
    logic [ARB_ID_W-1:0] grant_q, grant_d;
    logic [ARB_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    arb_beat_t           out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic [NLAYERS-1:0]  stat_grant_q, stat_grant_d;

    logic [ARB_ID_W-1:0] pick_idx;
    logic                pick_found;
    logic [7:0]          sel_data, sel_dest;
    logic                sel_last, sel_valid;
    logic                out_free, lane_open, take;
    logic [ARB_ID_W-1:0] next_ptr;
    logic [NLAYERS-1:0]  grant_onehot;

    rr_priority_pick #(
        .N    (NLAYERS),
        .ID_W (ARB_ID_W)
    ) u_pick (
        .req_i    (s_axis_tvalid & cfg_layer_enable),
        .ptr_i    (rr_ptr_q),
        .winner_o (pick_idx),
        .found_o  (pick_found)
    );

    // Lane selected by the current grant
    always_comb begin
        sel_data  = '0;
        sel_dest  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int unsigned i = 0; i < NLAYERS; i++) begin
            if (grant_q == ARB_ID_W'(i)) begin
                sel_data  = s_axis_tdata[8*i +: 8];
                sel_dest  = s_axis_tdest[8*i +: 8];
                sel_last  = s_axis_tlast[i];
                sel_valid = s_axis_tvalid[i];
            end
        end
    end

    assign out_free     = !out_valid_q || m_axis_tready;
    assign next_ptr     = (grant_q == ARB_ID_W'(NLAYERS - 1)) ? '0 : grant_q + ARB_ID_W'(1);
    assign grant_onehot = NLAYERS'(1) << grant_q;

`ifdef LAYERS_ARB_TIMEOUT_EN
    logic [ARB_TIMEOUT_W-1:0] stall_q, stall_d;
    logic [ARB_TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
    logic                     timeout_hit;

    assign timeout_hit        = (cfg_timeout != '0) && (stall_q == cfg_timeout);
    assign lane_open          = out_free && !timeout_hit;
    assign stat_timeout_count = to_cnt_q;
`else
    logic unused_cfg_timeout;

    assign unused_cfg_timeout = ^cfg_timeout;
    assign lane_open          = out_free;
    assign stat_timeout_count = '0;
`endif

    // Next-state, output register and ready logic
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        out_d         = out_q;
        out_valid_d   = out_valid_q;
        take          = 1'b0;
        s_axis_tready = '0;
`ifdef LAYERS_ARB_TIMEOUT_EN
        stall_d       = stall_q;
        to_cnt_d      = to_cnt_q;
`endif
        if (out_valid_q && m_axis_tready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                s_axis_tready = lane_open ? grant_onehot : '0;
                take          = lane_open && sel_valid;
                if (take) begin
                    out_d       = '{last: sel_last, dest: sel_dest, data: sel_data};
                    out_valid_d = 1'b1;
                    if (sel_last) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
`ifdef LAYERS_ARB_TIMEOUT_EN
                if (take) begin
                    stall_d = '0;
                end else if (timeout_hit) begin
                    stall_d = '0;
                    state_d = ST_FLUSH;
                end else if (!sel_valid && stall_q != '1) begin
                    stall_d = stall_q + ARB_TIMEOUT_W'(1);
                end
`endif
            end
`ifdef LAYERS_ARB_TIMEOUT_EN
            // Close the stalled frame with a filler tlast beat
            ST_FLUSH: begin
                if (out_free) begin
                    out_d       = '{last: 1'b1, dest: sel_dest, data: ARB_FILLER_BYTE};
                    out_valid_d = 1'b1;
                    rr_ptr_d    = next_ptr;
                    state_d     = ST_IDLE;
                    if (to_cnt_q != '1) begin
                        to_cnt_d = to_cnt_q + ARB_TIMEOUT_W'(1);
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        stat_grant_d = (state_d != ST_IDLE) ? (NLAYERS'(1) << grant_d) : '0;
    end

    always_ff @(posedge clk_core or posedge clk_core_rst) begin
        if (clk_core_rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            stat_grant_q <= '0;
`ifdef LAYERS_ARB_TIMEOUT_EN
            stall_q      <= '0;
            to_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            stat_grant_q <= stat_grant_d;
`ifdef LAYERS_ARB_TIMEOUT_EN
            stall_q      <= stall_d;
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    assign m_axis_tdata  = out_q.data;
    assign m_axis_tdest  = out_q.dest;
    assign m_axis_tlast  = out_q.last;
    assign m_axis_tvalid = out_valid_q;
    assign stat_grant    = stat_grant_q;

endmodule
